// File: rtl/sprite_motion_engine_pkg.sv
// sprite_motion_engine_pkg: playfield constants, sequencer states and id-width helper
package sprite_motion_engine_pkg;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UPDATE = 1'b1;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sprite_motion_engine_hit_test.sv
// sprite_motion_engine_hit_test: decides whether a pixel falls inside one sprite's box and mask
module sprite_motion_engine_hit_test #(
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int GROUND_Y   = 384,
    parameter int ROUND_MASK = 1
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       hit
);
    localparam logic signed [11:0] HW    = 12'(SPRITE_W / 2);
    localparam logic signed [11:0] HH    = 12'(SPRITE_H / 2);
    localparam logic signed [11:0] MID_Y = 12'(GROUND_Y - SPRITE_H + SPRITE_H / 2);
    localparam logic signed [23:0] R2    = 24'((SPRITE_W / 2) * (SPRITE_W / 2));
    logic signed [11:0] ox, oy;
    logic signed [23:0] d2;
    // offsets from the sprite centre; the box test is then a symmetric range check
    always_comb begin
        ox = $signed({2'b0, hpos}) - $signed({2'b0, x}) - HW;
        oy = $signed({2'b0, vpos}) + $signed({2'b0, y}) - MID_Y;
        d2 = 24'(ox) * 24'(ox) + 24'(oy) * 24'(oy);
        hit = ox >= -HW && ox < HW && oy >= -HH && oy < HH && (ROUND_MASK == 0 || d2 < R2);
    end
endmodule

// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: per-frame sprite bounce/jump physics with registered per-pixel hit test
module sprite_motion_engine
    import sprite_motion_engine_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int SCREEN_W    = SCREEN_WIDTH,
    parameter int GROUND_Y    = 384,
    parameter int SPEED_X     = 1,
    parameter int JUMP_VEL    = 12,
    parameter int GRAVITY     = 1,
    parameter int ROUND_MASK  = 1,
    localparam int ID_W       = id_width(NUM_SPRITES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_end,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic [NUM_SPRITES-1:0] jump,
    output logic                   o_hit,
    output logic [ID_W-1:0]        o_hit_id,
    output logic                   o_busy,
    output logic                   o_overrun
);
    localparam logic [10:0]        X_MAX = 11'(SCREEN_W - SPRITE_W);
    localparam logic signed [10:0] Y_MAX = 11'(GROUND_Y - SPRITE_H);
    logic [9:0]             x [NUM_SPRITES];
    logic [9:0]             y [NUM_SPRITES];
    logic signed [7:0]      vy [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] dx, jump_req, clr, hits;
    logic [0:0]             state;
    logic [ID_W-1:0]        idx, hit_id;
    logic [9:0]             cx, cy, nx, ny;
    logic signed [7:0]      cvy, nvy;
    logic signed [10:0]     nv, sum;
    logic                   upd, cdx, ndx, x_hi, x_lo, grounded, consume;
    assign upd    = state == ST_UPDATE;
    assign o_busy = upd;
    // next state of the sprite currently addressed by the sequencer
    always_comb begin
        cx = x[idx];
        cy = y[idx];
        cvy = vy[idx];
        cdx = dx[idx];
        x_hi = cdx && 11'(cx) + 11'(SPEED_X) >= X_MAX;
        x_lo = !cdx && cx <= 10'(SPEED_X);
        nx = x_hi ? 10'(X_MAX) : x_lo ? 10'd0 : cdx ? cx + 10'(SPEED_X) : cx - 10'(SPEED_X);
        ndx = x_hi ? 1'b0 : x_lo ? 1'b1 : cdx;
        grounded = cy == 10'd0 && cvy == 8'sd0;
        consume = upd && grounded && jump_req[idx];
        nv = 11'(cvy) - 11'(GRAVITY);
        sum = $signed({1'b0, cy}) + nv;
        ny = grounded ? (consume ? 10'(JUMP_VEL) : 10'd0) : sum <= 0 ? 10'd0 : sum >= Y_MAX ? 10'(Y_MAX) : sum[9:0];
        nvy = grounded ? (consume ? 8'(JUMP_VEL) : 8'sd0) : (sum <= 0 || sum >= Y_MAX) ? 8'sd0 : nv[7:0];
        clr = '0;
        clr[idx] = consume;
    end
    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_hit
        sprite_motion_engine_hit_test #(
            .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .GROUND_Y(GROUND_Y), .ROUND_MASK(ROUND_MASK)
        ) u_hit (
            .x(x[s]), .y(y[s]), .hpos(hpos), .vpos(vpos), .hit(hits[s])
        );
    end
    always_comb begin
        hit_id = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) hit_id = hits[i] ? ID_W'(i) : hit_id;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x[i]  <= 10'(i * 2 * SPRITE_W);
                y[i]  <= '0;
                vy[i] <= '0;
            end
            dx        <= '1;
            jump_req  <= '0;
            state     <= ST_IDLE;
            idx       <= '0;
            o_hit     <= 1'b0;
            o_hit_id  <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (upd) begin
                x[idx]  <= nx;
                dx[idx] <= ndx;
                y[idx]  <= ny;
                vy[idx] <= nvy;
            end
            jump_req  <= (jump_req & ~clr) | jump;
            state     <= upd ? (idx == ID_W'(NUM_SPRITES - 1) ? ST_IDLE : ST_UPDATE) : (frame_end ? ST_UPDATE : ST_IDLE);
            idx       <= (upd && idx != ID_W'(NUM_SPRITES - 1)) ? idx + 1'b1 : '0;
            o_overrun <= upd && frame_end;
            o_hit     <= |hits;
            o_hit_id  <= hit_id;
        end
    end
endmodule
